// File: rtl/ready_rr_arb_pkg.sv
// Shared constants and the round-robin pick function for ready_rr_arb.
package ready_arb_pkg;

  localparam int MAX_REQ = 16;

  // One-hot grant: first valid requester found scanning from ptr+1, wrapping at num_req.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [3:0]         ptr,
    input int                 num_req
  );
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int                 idx;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      if (i <= num_req) begin
        idx = int'(ptr) + i;
        if (idx >= num_req) idx = idx - num_req;
        if (!found && valid[idx[3:0]]) begin
          gnt[idx[3:0]] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/ready_rr_arb_if.sv
// Requester channels plus the single output channel of ready_rr_arb.
// The lock_i vector exists only when READY_RR_ARB_LOCK_EN is defined.
interface ready_rr_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 12
);
  localparam int SRC_W = $clog2(NUM_REQ);

  // Handshake: a word moves on a posedge where valid and ready are both high;
  // a raised valid must stay high with stable data until accepted.
  logic [NUM_REQ-1:0]       valid_i;
  logic [NUM_REQ-1:0]       ready_i;
  logic [NUM_REQ*WIDTH-1:0] dat_i;
  logic                     valid_o;
  logic                     ready_o;
  logic [WIDTH-1:0]         dat_o;
  logic [SRC_W-1:0]         src_o;
`ifdef READY_RR_ARB_LOCK_EN
  logic [NUM_REQ-1:0]       lock_i;

  modport master (
    output valid_i, dat_i, ready_o, lock_i,
    input  ready_i, valid_o, dat_o, src_o
  );

  modport slave (
    input  valid_i, dat_i, ready_o, lock_i,
    output ready_i, valid_o, dat_o, src_o
  );
`else
  modport master (
    output valid_i, dat_i, ready_o,
    input  ready_i, valid_o, dat_o, src_o
  );

  modport slave (
    input  valid_i, dat_i, ready_o,
    output ready_i, valid_o, dat_o, src_o
  );
`endif

endinterface

// File: rtl/ready_rr_arb_rr_grant.sv
// Combinational rotate/priority-encode: one-hot grant and its index from valid and ptr.
module rr_grant
  import ready_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SRC_W-1:0]   idx,
  output logic               any
);

  logic [MAX_REQ-1:0] valid_ext;
  logic [MAX_REQ-1:0] pick;
  logic               pick_unused;

  always_comb begin
    valid_ext              = '0;
    valid_ext[NUM_REQ-1:0] = valid;
  end

  assign pick        = rr_pick(valid_ext, 4'(ptr), NUM_REQ);
  assign pick_unused = |pick;
  assign gnt         = pick[NUM_REQ-1:0];
  assign any         = |gnt;

  always_comb begin
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) idx = SRC_W'(k);
    end
  end

endmodule

// File: rtl/ready_rr_arb.sv
// Round-robin arbiter: NUM_REQ valid/ready requesters onto one registered output channel.
// Define READY_RR_ARB_LOCK_EN to add lock_i for contiguous multi-word packets.
module ready_rr_arb
  import ready_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 12
) (
  input  logic           clk,
  input  logic           arst_n,
  ready_rr_arb_if.slave  bus
);

  localparam int SRC_W = $clog2(NUM_REQ);

  logic [SRC_W-1:0]   ptr;
  logic [NUM_REQ-1:0] valid_eff;
  logic [NUM_REQ-1:0] gnt;
  logic [SRC_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               load_ok;
  logic               xfer;
  logic [WIDTH-1:0]   dat_sel;

  logic               valid_q;
  logic [WIDTH-1:0]   dat_q;
  logic [SRC_W-1:0]   src_q;

`ifdef READY_RR_ARB_LOCK_EN
  logic               locked;
  logic [SRC_W-1:0]   lock_src;

  // While locked, only lock_src is eligible; ptr is untouched so rotation resumes from it.
  always_comb begin
    valid_eff = bus.valid_i;
    if (locked) valid_eff = bus.valid_i & (NUM_REQ'(1) << lock_src);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      locked   <= 1'b0;
      lock_src <= '0;
    end else if (xfer) begin
      if (bus.lock_i[gnt_idx]) begin
        locked   <= 1'b1;
        lock_src <= gnt_idx;
      end else begin
        locked   <= 1'b0;
      end
    end
  end
`else
  assign valid_eff = bus.valid_i;
`endif

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_grant (
    .valid (valid_eff),
    .ptr   (ptr),
    .gnt   (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign load_ok     = !valid_q || bus.ready_o;
  assign bus.ready_i = gnt & {NUM_REQ{load_ok}};
  assign xfer        = gnt_any && load_ok;

  // Data mux is steered by gnt only, so ready_i never depends on dat_i.
  always_comb begin
    dat_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) dat_sel = bus.dat_i[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q <= 1'b0;
      dat_q   <= '0;
      src_q   <= '0;
      ptr     <= SRC_W'(NUM_REQ - 1);
    end else if (xfer) begin
      valid_q <= 1'b1;
      dat_q   <= dat_sel;
      src_q   <= gnt_idx;
      ptr     <= gnt_idx;
    end else if (bus.ready_o) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.dat_o   = dat_q;
  assign bus.src_o   = src_q;

endmodule

// File: tb/tb_ready_rr_arb.sv
// Directed and randomised self-checking bench for ready_rr_arb (NUM_REQ=4, WIDTH=12).
module tb_ready_rr_arb;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 12;
  localparam int SRC_W   = 2;

  logic clk = 1'b0;
  logic arst_n;
  int   checks   = 0;
  int   failures = 0;
  logic [SRC_W+WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  ready_rr_arb_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  ready_rr_arb #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic static_data();
    for (int k = 0; k < NUM_REQ; k++) bus.dat_i[k*WIDTH +: WIDTH] = WIDTH'(16 + k);
  endtask

  task automatic do_reset();
    arst_n      = 1'b0;
    bus.valid_i = '0;
    bus.ready_o = 1'b1;
`ifdef READY_RR_ARB_LOCK_EN
    bus.lock_i  = '0;
`endif
    static_data();
    cycle();
    cycle();
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", bus.valid_o); end
    checks++; if (bus.src_o !== 2'd0) begin failures++; $display("FAIL reset_src got=%0h exp=0", bus.src_o); end
    checks++; if (bus.dat_o !== 12'h0) begin failures++; $display("FAIL reset_dat got=%0h exp=0", bus.dat_o); end
    bus.valid_i = 4'b1111;
    #1;
    checks++; if (bus.ready_i !== 4'b0001) begin failures++; $display("FAIL reset_first_ready got=%0b exp=0001", bus.ready_i); end
    cycle();
    cycle();
    checks++; if (bus.src_o !== 2'd1 || bus.valid_o !== 1'b1) begin failures++; $display("FAIL reset_pre_src got=%0h/%0b exp=1/1", bus.src_o, bus.valid_o); end
    arst_n = 1'b0;
    #1;
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_mid_valid got=%0h exp=0", bus.valid_o); end
    checks++; if (bus.src_o !== 2'd0) begin failures++; $display("FAIL reset_mid_src got=%0h exp=0", bus.src_o); end
    checks++; if (bus.dat_o !== 12'h0) begin failures++; $display("FAIL reset_mid_dat got=%0h exp=0", bus.dat_o); end
    cycle();
    arst_n = 1'b1;
    #1;
    checks++; if (bus.ready_i !== 4'b0001) begin failures++; $display("FAIL reset_ptr_ready got=%0b exp=0001", bus.ready_i); end
    cycle();
    checks++; if (bus.src_o !== 2'd0 || bus.dat_o !== 12'h010) begin failures++; $display("FAIL reset_first_grant got=%0h/%0h exp=0/010", bus.src_o, bus.dat_o); end
  endtask

  task automatic test_rotation();
    logic [SRC_W-1:0] exp_src;
    do_reset();
    bus.valid_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      cycle();
      exp_src = SRC_W'(i % 4);
      checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL rot_valid[%0d] got=%0b exp=1", i, bus.valid_o); end
      checks++; if (bus.src_o !== exp_src) begin failures++; $display("FAIL rot_src[%0d] got=%0h exp=%0h", i, bus.src_o, exp_src); end
      checks++; if (bus.dat_o !== WIDTH'(16 + i % 4)) begin failures++; $display("FAIL rot_dat[%0d] got=%0h exp=%0h", i, bus.dat_o, 16 + i % 4); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.valid_i = 4'b1111;
    repeat (3) cycle();
    checks++; if (bus.src_o !== 2'd2 || bus.dat_o !== 12'h012) begin failures++; $display("FAIL bp_setup got=%0h/%0h exp=2/012", bus.src_o, bus.dat_o); end
    bus.ready_o = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.ready_i !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%0b exp=0000", i, bus.ready_i); end
      cycle();
      checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%0b exp=1", i, bus.valid_o); end
      checks++; if (bus.src_o !== 2'd2) begin failures++; $display("FAIL bp_src[%0d] got=%0h exp=2", i, bus.src_o); end
      checks++; if (bus.dat_o !== 12'h012) begin failures++; $display("FAIL bp_dat[%0d] got=%0h exp=012", i, bus.dat_o); end
    end
    bus.ready_o = 1'b1;
    cycle();
    checks++; if (bus.src_o !== 2'd3) begin failures++; $display("FAIL bp_resume got=%0h exp=3", bus.src_o); end
  endtask

  task automatic test_sparse();
    logic [SRC_W-1:0] exp_seq[3];
    exp_seq = '{2'd3, 2'd0, 2'd3};
    do_reset();
    bus.valid_i = 4'b0001;
    cycle();
    bus.valid_i = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.ready_i !== ((exp_seq[i] == 2'd3) ? 4'b1000 : 4'b0001)) begin failures++; $display("FAIL sparse_ready[%0d] got=%0b exp_src=%0h", i, bus.ready_i, exp_seq[i]); end
      cycle();
      checks++; if (bus.src_o !== exp_seq[i]) begin failures++; $display("FAIL sparse_src[%0d] got=%0h exp=%0h", i, bus.src_o, exp_seq[i]); end
    end
    bus.valid_i = 4'b0000;
    cycle();
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL idle_valid got=%0b exp=0", bus.valid_o); end
    checks++; if (bus.src_o !== 2'd3 || bus.dat_o !== 12'h013) begin failures++; $display("FAIL idle_hold got=%0h/%0h exp=3/013", bus.src_o, bus.dat_o); end
    cycle();
    bus.valid_i = 4'b1111;
    #1;
    checks++; if (bus.ready_i !== 4'b0001) begin failures++; $display("FAIL idle_ptr got=%0b exp=0001", bus.ready_i); end
  endtask

  task automatic test_single();
    do_reset();
    bus.valid_i = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.ready_i !== 4'b0100) begin failures++; $display("FAIL single_ready[%0d] got=%0b exp=0100", i, bus.ready_i); end
      cycle();
      checks++; if (bus.valid_o !== 1'b1 || bus.src_o !== 2'd2) begin failures++; $display("FAIL single_out[%0d] got=%0b/%0h exp=1/2", i, bus.valid_o, bus.src_o); end
    end
  endtask

`ifdef READY_RR_ARB_LOCK_EN
  task automatic test_lock();
    logic [SRC_W-1:0]   exp_src[6];
    logic [NUM_REQ-1:0] lock_seq[6];
    exp_src  = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    lock_seq = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    do_reset();
    bus.valid_i = 4'b1111;
    cycle();
    for (int i = 0; i < 6; i++) begin
      bus.lock_i = lock_seq[i];
      cycle();
      checks++; if (bus.src_o !== exp_src[i]) begin failures++; $display("FAIL lock_src[%0d] got=%0h exp=%0h", i, bus.src_o, exp_src[i]); end
    end
    bus.lock_i = '0;
  endtask
`endif

  task automatic test_soak();
    logic [NUM_REQ-1:0]     pend;
    logic [NUM_REQ-1:0]     hs;
    logic [7:0]             seq[NUM_REQ];
    int                     wait_cnt[NUM_REQ];
    logic [SRC_W+WIDTH-1:0] exp_w;
    logic [SRC_W+WIDTH-1:0] got_w;
    do_reset();
    exp_q.delete();
    pend = '0;
    for (int k = 0; k < NUM_REQ; k++) begin seq[k] = 8'h0; wait_cnt[k] = 0; end
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!pend[k] && ($urandom_range(0, 1) == 1)) begin
          pend[k] = 1'b1;
          bus.dat_i[k*WIDTH +: WIDTH] = {4'(k), seq[k]};
        end
      end
      bus.valid_i = pend;
      bus.ready_o = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (!$onehot0(bus.ready_i)) begin failures++; $display("FAIL soak_onehot[%0d] got=%0b exp=onehot0", c, bus.ready_i); end
      if (bus.valid_o && bus.ready_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL soak_unexpected[%0d] got=%0h/%0h exp=none", c, bus.src_o, bus.dat_o);
        end else begin
          exp_w = exp_q.pop_front();
          got_w = {bus.src_o, bus.dat_o};
          if (got_w !== exp_w) begin failures++; $display("FAIL soak_word[%0d] got=%0h exp=%0h", c, got_w, exp_w); end
        end
      end
      hs = pend & bus.ready_i;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (hs[k]) begin
          checks++; if (wait_cnt[k] > NUM_REQ - 1) begin failures++; $display("FAIL soak_fair[%0d] req=%0d got=%0d exp<=%0d", c, k, wait_cnt[k], NUM_REQ - 1); end
          wait_cnt[k] = 0;
          exp_q.push_back({SRC_W'(k), bus.dat_i[k*WIDTH +: WIDTH]});
        end else if (pend[k] && hs != '0) begin
          wait_cnt[k]++;
        end
      end
      cycle();
      for (int k = 0; k < NUM_REQ; k++) if (hs[k]) seq[k] = seq[k] + 8'h1;
      pend = pend & ~hs;
    end
    bus.valid_i = '0;
    bus.ready_o = 1'b1;
    for (int d = 0; d < 3; d++) begin
      #1;
      if (bus.valid_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL drain_unexpected got=%0h/%0h exp=none", bus.src_o, bus.dat_o);
        end else begin
          exp_w = exp_q.pop_front();
          got_w = {bus.src_o, bus.dat_o};
          if (got_w !== exp_w) begin failures++; $display("FAIL drain_word got=%0h exp=%0h", got_w, exp_w); end
        end
      end
      cycle();
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL drain_left got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    arst_n      = 1'b0;
    bus.valid_i = '0;
    bus.ready_o = 1'b1;
    bus.dat_i   = '0;
`ifdef READY_RR_ARB_LOCK_EN
    bus.lock_i  = '0;
`endif
    test_reset();
    test_rotation();
    test_backpressure();
    test_sparse();
    test_single();
`ifdef READY_RR_ARB_LOCK_EN
    test_lock();
`endif
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ready_rr_arb.md
Name: ready_rr_arb

Overview:
- Round-robin arbiter sharing one valid/ready stream (e.g. a downstream ready_skid) between NUM_REQ requesters.
- Each requester presents a valid/ready/data channel.
- The block selects one requester per transfer, registers the winning word plus its source index, and presents it on a single output channel.
- Full throughput: one word per clock while the sink keeps ready_o high.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- WIDTH, 12: data width per word.
- SRC_W, $clog2(NUM_REQ): localparam, width of the source index. Not overridable.

Ports:
- clk  in  1: single clock, all logic on posedge.
- arst_n  in  1: asynchronous reset, active-low. Asserts immediately; deasserts synchronised externally.
- valid_i  in  NUM_REQ: per-requester word valid.
- dat_i  in  NUM_REQ*WIDTH: packed data; requester k occupies bits [k*WIDTH +: WIDTH].
- ready_i  out  NUM_REQ: per-requester accept. Combinational; at most one bit high.
- valid_o  out  1: output word valid (registered).
- dat_o  out  WIDTH: output word (registered).
- src_o  out  SRC_W: index of the requester that supplied dat_o (registered).
- ready_o  in  1: sink accept.

Behaviour:
- Reset (arst_n low, any time, including mid-transfer):
  - valid_o=0, dat_o=0, src_o=0.
  - Priority pointer ptr=NUM_REQ-1, so requester 0 ranks highest after reset.
  - A word in flight is discarded.
- Output stage can load: load_ok = !valid_o | ready_o.
- Grant (combinational):
  - Scan requesters starting at ptr+1 mod NUM_REQ, wrapping.
  - First k with valid_i[k]=1 wins, giving a one-hot gnt.
  - No valid_i bit set gives gnt=0.
- ready_i = gnt & {NUM_REQ{load_ok}}. ready_i[k] must not depend on dat_i.
- Transfer on requester k: valid_i[k] & ready_i[k]. On that posedge:
  - dat_o <= dat_i[k]; src_o <= k; valid_o <= 1; ptr <= k.
- No transfer and ready_o=1: valid_o <= 0. dat_o and src_o hold their last values.
- valid_o=1 and ready_o=0: dat_o, src_o and valid_o hold; all ready_i=0.
- Latency: 1 clock from input handshake to valid_o.
- ptr changes only on a transfer. An idle cycle does not rotate priority.
- Single active requester: granted every cycle at full rate, no bubbles.
- All NUM_REQ active and ready_o=1 constantly: strict rotation 0,1,..,NUM_REQ-1,0...
  - Fairness bound: a waiting requester is granted within NUM_REQ transfers.
- Requester drops valid_i while not granted: no state is retained for it.
- Requesters may not withdraw valid once raised until accepted (AXI-style rule). The block does not check this.
- ptr wraps at NUM_REQ-1 → 0. NUM_REQ need not be a power of two; ptr never holds a value ≥ NUM_REQ.

Optional Feature:
- Macro READY_RR_ARB_LOCK_EN.
- Defined:
  - Adds port lock_i  in  NUM_REQ.
  - A transfer from requester k with lock_i[k]=1 sets locked=1 and lock_src=k.
  - While locked, gnt is forced to lock_src regardless of other valid_i bits.
  - Released by a transfer from lock_src with lock_i=0. That transfer completes normally, then rotation resumes from ptr=lock_src.
  - Reset clears locked.
  - Use case: multi-word packets delivered contiguously.
- Undefined: port absent, pure per-word round-robin as above.

Decomposition:
- Package ready_arb_pkg:
  - function rr_pick(valid vector, ptr) returning a one-hot grant.
  - localparam MAX_REQ=16.
- Sub-module rr_grant: combinational rotate/priority-encode, taking valid and ptr and producing one-hot gnt plus encoded index.
- ready_rr_arb instantiates rr_grant and owns ptr, the output register and the lock state.

Test Plan:
- Reset: drive arst_n low mid-stream with valid_o=1 → valid_o=0, src_o=0 immediately. First grant after release goes to requester 0 when all valid_i=4'b1111.
- Full rotation: NUM_REQ=4, valid_i=4'b1111, ready_o=1 for 8 cycles, dat_i[k]=k+8'h10 → src_o sequence 0,1,2,3,0,1,2,3; dat_o 0x10..0x13 repeating; no bubbles.
- Backpressure: valid_o=1, src_o=2, dat_o=0x12, then ready_o=0 for 3 cycles → dat_o, src_o and valid_o stable; ready_i=0 throughout.
- Sparse/wrap: valid_i=4'b1001 with ptr=0 → grant 3, then 0, then 3. valid_i=0 with ready_o=1 → valid_o drops next cycle; ptr unchanged.
- Lock (READY_RR_ARB_LOCK_EN): requester 1 sends 3 words with lock_i[1]=1,1,0 while valid_i=4'b1111 → src_o=1,1,1, then 2,3,0.
- Random soak: random valid_i and ready_o. Scoreboard per-source ordering; check at most one ready_i bit high per cycle and the fairness bound of ≤ NUM_REQ transfers per waiting requester.
